// File: rtl/logic_probe_mc.sv
// Multi-channel logic probe: synchronised window-comparator inputs, per-channel time/edge
// counters over a programmable gate, double-buffered snapshots and a per-gate interrupt.
module logic_probe_mc #(
    parameter int unsigned CHANNELS       = 2,
    parameter int unsigned COUNTERS_WIDTH = 28,
    parameter int unsigned DEFAULT_PERIOD = 2700000,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic                clk,
    input  logic                nreset,
    input  logic [CHANNELS-1:0] comp_data_hi,
    input  logic [CHANNELS-1:0] comp_data_lo,
    input  logic [4:0]          address,
    input  logic                data_request,
    input  logic                write,
    input  logic [31:0]         data_in,
    output logic [31:0]         data,
    output logic                data_ready,
    output logic                interrupt,
    input  logic                interrupt_clear
);

    localparam int unsigned NITEMS = 6;
    localparam logic [7:0]  CH8    = 8'(CHANNELS);

    typedef logic [COUNTERS_WIDTH-1:0] cnt_t;
    localparam cnt_t ONE = cnt_t'(1);

    logic [SYNC_STAGES-1:0] sync_hi [CHANNELS];
    logic [SYNC_STAGES-1:0] sync_lo [CHANNELS];

    logic [CHANNELS-1:0] h, l, hp, lp, rs, rs_prev;
    logic [NITEMS-1:0]   inc    [CHANNELS];
    cnt_t                live   [CHANNELS][NITEMS];
    cnt_t                bumped [CHANNELS][NITEMS];
    cnt_t                shadow [CHANNELS][NITEMS];

    logic [31:0] period;
    logic [31:0] gate_cnt;
    logic        overrun;
    logic        period_wr;
    logic        snapshot;
    logic [1:0]  sel_ch;
    logic [2:0]  sel_item;
    logic [31:0] rd_val;

    assign period_wr = write && (address[2:0] == 3'd7);
    assign snapshot  = !period_wr && (gate_cnt == period - 32'd1);
    assign sel_ch    = address[4:3];
    assign sel_item  = address[2:0];

    // Item order: t_high, t_low, t_z, e_hi, e_lo, e_rs; increments saturate at all-ones
    always_comb begin
        h      = '0;
        l      = '0;
        inc    = '{default: '0};
        bumped = '{default: '0};
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            h[c] = sync_hi[c][SYNC_STAGES-1];
            l[c] = sync_lo[c][SYNC_STAGES-1];
            inc[c][0] = h[c];
            inc[c][1] = l[c];
            inc[c][2] = !h[c] && !l[c];
            inc[c][3] = h[c] && !hp[c];
            inc[c][4] = l[c] && !lp[c];
            inc[c][5] = rs[c] && !rs_prev[c];
            for (int unsigned i = 0; i < NITEMS; i++) begin
                if (inc[c][i] && (live[c][i] != '1))
                    bumped[c][i] = live[c][i] + ONE;
                else
                    bumped[c][i] = live[c][i];
            end
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                sync_hi[c] <= '0;
                sync_lo[c] <= '0;
                for (int unsigned i = 0; i < NITEMS; i++) begin
                    live[c][i]   <= '0;
                    shadow[c][i] <= '0;
                end
            end
            hp      <= '0;
            lp      <= '0;
            rs      <= '0;
            rs_prev <= '0;
        end else begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                sync_hi[c] <= {sync_hi[c][SYNC_STAGES-2:0], comp_data_hi[c]};
                sync_lo[c] <= {sync_lo[c][SYNC_STAGES-2:0], comp_data_lo[c]};
                hp[c]      <= h[c];
                lp[c]      <= l[c];
                rs[c]      <= h[c] | (rs[c] & ~l[c]);
                rs_prev[c] <= rs[c];
                // Snapshot takes this cycle's increment; the new gate starts already holding it
                for (int unsigned i = 0; i < NITEMS; i++) begin
                    if (period_wr) begin
                        live[c][i] <= '0;
                    end else if (snapshot) begin
                        shadow[c][i] <= bumped[c][i];
                        live[c][i]   <= inc[c][i] ? ONE : '0;
                    end else begin
                        live[c][i] <= bumped[c][i];
                    end
                end
            end
        end
    end

    always_comb begin
        rd_val = '0;
        case (sel_item)
            3'd6:    rd_val = {16'h0000, CH8, 6'b000000, interrupt, overrun};
            3'd7:    rd_val = period;
            default: begin
                for (int unsigned c = 0; c < CHANNELS; c++) begin
                    for (int unsigned i = 0; i < NITEMS; i++) begin
                        if (sel_ch == 2'(c) && sel_item == 3'(i))
                            rd_val = 32'(shadow[c][i]);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            data       <= '0;
            data_ready <= 1'b0;
            period     <= 32'(DEFAULT_PERIOD);
            gate_cnt   <= '0;
            interrupt  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            data_ready <= data_request;
            if (data_request)
                data <= rd_val;

            if (period_wr) begin
                period   <= (data_in < 32'd2) ? 32'd2 : data_in;
                gate_cnt <= '0;
            end else if (snapshot) begin
                gate_cnt <= '0;
            end else begin
                gate_cnt <= gate_cnt + 32'd1;
            end

            // A snapshot wins over a simultaneous clear and leaves overrun as it was
            if (snapshot) begin
                interrupt <= 1'b1;
                if (interrupt && !interrupt_clear)
                    overrun <= 1'b1;
            end else if (interrupt_clear) begin
                interrupt <= 1'b0;
                overrun   <= 1'b0;
            end
        end
    end

endmodule
